// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: producer/consumer handshake, status and error bundle for fifo_sync_param.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  half;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;
    modport master (
        output flush, wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, half, count, overflow, underflow
    );
    modport slave (
        input  flush, wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, half, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with thresholds, occupancy count, sticky errors,
// synchronous flush and selectable registered / first-word-fall-through read.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0
) (
    input logic clk,
    input logic rst,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);

    if (DATA_WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
        AE_LEVEL <= 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL >= DEPTH) begin : g_bad_params
        $error("fifo_sync_param: illegal parameter set");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rv;
    logic                  ovf;
    logic                  unf;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = cnt == DEPTH_C;
    assign empty = cnt == '0;
    assign wr_ok = bus.wr_en && !full;
    assign rd_ok = bus.rd_en && !empty;

    always_ff @(posedge clk)
        if (!rst && !bus.flush && wr_ok)
            mem[wptr] <= bus.wr_data;

    // Errors set only for operations that were actually considered (not during flush); set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            rd_q <= '0;
            rv   <= 1'b0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            ovf <= (bus.wr_en && full && !bus.flush) || (ovf && !bus.err_clr);
            unf <= (bus.rd_en && empty && !bus.flush) || (unf && !bus.err_clr);
            if (bus.flush) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                rv   <= 1'b0;
            end else begin
                if (wr_ok)
                    wptr <= wptr + 1'b1;
                if (rd_ok) begin
                    rptr <= rptr + 1'b1;
                    rd_q <= mem[rptr];
                end
                cnt <= cnt + CW'(wr_ok) - CW'(rd_ok);
                rv  <= rd_ok;
            end
        end
    end

    assign bus.rd_data      = (FWFT != 0) ? mem[rptr] : rd_q;
    assign bus.rd_valid     = (FWFT != 0) ? !empty : rv;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = cnt >= AF_C;
    assign bus.almost_empty = cnt <= AE_C;
    assign bus.half         = cnt >= HALF_C;
    assign bus.count        = cnt;
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed checks of a registered-read and a fall-through instance.
module tb_fifo_sync_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_WIDTH(8), .DEPTH(16)) b0 ();
    fifo_sync_param_if #(.DATA_WIDTH(8), .DEPTH(16)) b1 ();

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, 32'(b0.count), 0);
        chk({tag, "_empty"}, 32'(b0.empty), 1);
        chk({tag, "_ae"}, 32'(b0.almost_empty), 1);
        chk({tag, "_full"}, 32'(b0.full), 0);
        chk({tag, "_af"}, 32'(b0.almost_full), 0);
        chk({tag, "_half"}, 32'(b0.half), 0);
        chk({tag, "_rd_data"}, 32'(b0.rd_data), 0);
        chk({tag, "_rd_valid"}, 32'(b0.rd_valid), 0);
        chk({tag, "_ovf"}, 32'(b0.overflow), 0);
        chk({tag, "_unf"}, 32'(b0.underflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int nw;
        int e;
        logic w;
        logic r;
        {b0.flush, b0.wr_en, b0.rd_en, b0.err_clr} = '0;
        {b1.flush, b1.wr_en, b1.rd_en, b1.err_clr} = '0;
        b0.wr_data = '0;
        b1.wr_data = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset("reset");

        // fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            b0.wr_en = 1'b1;
            b0.wr_data = 8'(i);
            tick();
            chk("fill_count", 32'(b0.count), i + 1);
            chk("fill_af", 32'(b0.almost_full), 32'(i + 1 >= 12));
            chk("fill_half", 32'(b0.half), 32'(i + 1 >= 8));
            chk("fill_full", 32'(b0.full), 32'(i + 1 == 16));
            chk("fill_ae", 32'(b0.almost_empty), 32'(i + 1 <= 4));
        end

        b0.wr_data = 8'hAA;
        tick();
        b0.wr_en = 1'b0;
        chk("ovf_set", 32'(b0.overflow), 1);
        chk("ovf_count", 32'(b0.count), 16);
        for (int i = 0; i < 16; i++) begin
            b0.rd_en = 1'b1;
            tick();
            chk("drain_valid", 32'(b0.rd_valid), 1);
            chk("drain_data", 32'(b0.rd_data), i);
        end
        b0.rd_en = 1'b0;
        tick();
        chk("drain_valid_off", 32'(b0.rd_valid), 0);
        chk("drain_hold", 32'(b0.rd_data), 32'h0F);
        chk("drain_empty", 32'(b0.empty), 1);
        b0.err_clr = 1'b1;
        tick();
        b0.err_clr = 1'b0;
        chk("ovf_clr", 32'(b0.overflow), 0);

        b0.rd_en = 1'b1;
        tick();
        chk("unf_set", 32'(b0.underflow), 1);
        chk("unf_valid", 32'(b0.rd_valid), 0);
        b0.wr_en = 1'b1;
        b0.wr_data = 8'h33;
        tick();
        chk("rdwr_empty_count", 32'(b0.count), 1);
        chk("rdwr_empty_valid", 32'(b0.rd_valid), 0);
        b0.rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b0.wr_data = 8'(8'h34 + i);
            tick();
        end
        chk("pre_rdwr_count", 32'(b0.count), 5);
        b0.rd_en = 1'b1;
        b0.wr_data = 8'h38;
        tick();
        b0.wr_en = 1'b0;
        chk("rdwr5_count", 32'(b0.count), 5);
        chk("rdwr5_valid", 32'(b0.rd_valid), 1);
        chk("rdwr5_data", 32'(b0.rd_data), 32'h33);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rdwr5_order", 32'(b0.rd_data), 32'h34 + i);
        end
        b0.rd_en = 1'b0;
        tick();
        chk("rdwr5_empty", 32'(b0.empty), 1);

        // interleaved traffic across pointer wrap against a queue model
        nw = 0;
        for (int c = 0; c < 300; c++) begin
            if (nw == 40 && q.size() == 0)
                break;
            w = nw < 40 && q.size() < 14 && (c % 5 != 4);
            r = (nw == 40) ? (q.size() > 0) : (q.size() >= 3 && (c % 4 != 1));
            b0.wr_en = w;
            b0.rd_en = r;
            b0.wr_data = 8'(8'h40 + nw);
            tick();
            e = -1;
            if (r)
                e = q.pop_front();
            if (w) begin
                q.push_back(8'h40 + nw);
                nw++;
            end
            chk("wrap_count", 32'(b0.count), q.size());
            chk("wrap_valid", 32'(b0.rd_valid), 32'(r));
            if (r)
                chk("wrap_data", 32'(b0.rd_data), e);
        end
        b0.wr_en = 1'b0;
        b0.rd_en = 1'b0;
        chk("wrap_done", 32'(nw == 40 && q.size() == 0), 1);

        b0.wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b0.wr_data = 8'(8'h90 + i);
            tick();
        end
        chk("pre_flush_count", 32'(b0.count), 9);
        chk("pre_flush_unf", 32'(b0.underflow), 1);
        b0.flush = 1'b1;
        b0.wr_data = 8'hEE;
        tick();
        b0.flush = 1'b0;
        b0.wr_en = 1'b0;
        chk("flush_count", 32'(b0.count), 0);
        chk("flush_empty", 32'(b0.empty), 1);
        chk("flush_unf", 32'(b0.underflow), 1);
        chk("flush_valid", 32'(b0.rd_valid), 0);
        tick();
        chk("flush_wr_dropped", 32'(b0.count), 0);

        b0.wr_en = 1'b1;
        b0.wr_data = 8'h21;
        tick();
        b0.wr_data = 8'h22;
        tick();
        b0.wr_en = 1'b0;
        b0.rd_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b0.rd_en = 1'b0;
        chk_reset("rst_mid");

        b1.wr_en = 1'b1;
        b1.wr_data = 8'h5A;
        tick();
        b1.wr_en = 1'b0;
        chk("fwft_valid", 32'(b1.rd_valid), 1);
        chk("fwft_data", 32'(b1.rd_data), 32'h5A);
        tick();
        chk("fwft_hold_valid", 32'(b1.rd_valid), 1);
        chk("fwft_hold_count", 32'(b1.count), 1);
        b1.rd_en = 1'b1;
        tick();
        b1.rd_en = 1'b0;
        chk("fwft_pop_empty", 32'(b1.empty), 1);
        chk("fwft_pop_valid", 32'(b1.rd_valid), 0);
        b1.wr_en = 1'b1;
        b1.wr_data = 8'hA1;
        tick();
        b1.wr_data = 8'hA2;
        tick();
        b1.wr_en = 1'b0;
        chk("fwft_first", 32'(b1.rd_data), 32'hA1);
        b1.rd_en = 1'b1;
        tick();
        b1.rd_en = 1'b0;
        chk("fwft_second", 32'(b1.rd_data), 32'hA2);
        chk("fwft_second_valid", 32'(b1.rd_valid), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO; the next generation of the team's fixed-size fifo.
- Adds configurable width and depth, programmable almost-full/almost-empty thresholds and an occupancy count output.
- Adds sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in the same clock domain and is a drop-in replacement for the existing fifo port set.

Parameters:
DATA_WIDTH, 8, width of wr_data/rd_data in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=4
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
Legality (elaboration $error otherwise): DEPTH power of 2 and >=4; 0 < AE_LEVEL < AF_LEVEL < DEPTH.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous discard of all stored data
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request (pop in FWFT mode)
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data holds a valid word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
half  out  1  count >= DEPTH/2
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Priority per cycle: rst > flush > wr/rd operations.
- Reset values:
  - pointers and count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, half = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Write accepted iff wr_en && !full: mem[wptr] <= wr_data, wptr increments.
- Read accepted iff rd_en && !empty: rptr increments.
- Acceptance uses the registered count at the clock edge. On full, a simultaneous rd+wr accepts the read and rejects the write; on empty, a simultaneous rd+wr accepts the write and rejects the read.
- count next value: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- All status flags decode combinationally from the count register. They therefore change the cycle after the accepted operation; there is no same-cycle look-ahead.
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally. Occupancy comes from count, not pointer comparison.
- FWFT=0 (registered read):
  - On an accepted read, rd_data <= mem[rptr] and rd_valid = 1 in the next cycle only (1-cycle pulse).
  - Otherwise rd_valid = 0 and rd_data holds its last value.
- FWFT=1 (fall-through):
  - rd_data = mem[rptr] whenever !empty; rd_valid = !empty.
  - rd_en acts as pop/acknowledge of the presented word.
  - A write into an empty FIFO presents its word on rd_data one cycle after the write edge.
  - rd_data is don't-care when empty; the bench checks it only when rd_valid = 1.
- Sticky errors:
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Rejected operations change no other state.
  - err_clr clears both flags; if a new error occurs in the same cycle, set wins.
  - Flags are cleared only by rst or err_clr.
- flush:
  - Next cycle: pointers = 0, count = 0, rd_valid = 0; wr_en/rd_en are ignored in the flush cycle.
  - rd_data holds its value in FWFT=0 mode. Sticky flags are unaffected.
- rst mid-operation: any in-flight read result is discarded; state returns to reset values on the next edge.

Test Plan:
1. Reset then fill: DEPTH=16, 16 writes of 0x00..0x0F. Check: count 1..16; almost_full rises when count reaches 12; half rises at 8; full at 16; almost_empty falls when count reaches 5.
2. Overflow: with the FIFO full, write 0xAA. Check: overflow = 1, count stays 16, and drain returns 0x00..0x0F in order (FWFT=0: each word one cycle after rd_en). Then err_clr drops overflow.
3. Underflow and simultaneous ops:
   - Read when empty: underflow = 1, rd_valid stays 0.
   - rd+wr on empty: count becomes 1 and the read is rejected.
   - rd+wr at count = 5: count stays 5 and data order is preserved.
4. Wrap-around: perform 40 interleaved writes and reads of an incrementing pattern (count kept between 3 and 14). Check that every word reads back in order across pointer wrap and that count matches the reference model each cycle.
5. FWFT=1: write 0x5A into the empty FIFO. Check that the next cycle shows rd_valid = 1 and rd_data = 0x5A with no rd_en, and that rd_en pops it, giving empty = 1 one cycle later.
6. Flush/reset mid-stream:
   - At count = 9 with underflow already set, assert flush together with wr_en. Check: count = 0, empty = 1, underflow still 1, and the write is dropped.
   - rst during a read returns all outputs to reset values.
